// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and helpers for the sequential value display.
//   seg_t     : 7-segment pattern, active-low, bit order g..a (bit 6 = g)
//   SEG_*     : fixed patterns (all off, minus sign, overflow dash)
//   state_t   : conversion FSM states
//   bcd_add3  : double-dabble correction for one BCD nibble
//   pow10     : 10^n, used at elaboration time for the overflow limit
// -----------------------------------------------------------------------------
package display_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF   = 7'h7F;
   localparam seg_t SEG_MINUS = 7'b011_1111;
   localparam seg_t SEG_DASH  = 7'b011_1111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      UPDATE = 2'd2
   } state_t;

   // A nibble >= 5 would reach >= 10 after the next doubling, so pre-add 3
   // to make the carry land in the next decimal digit.
   function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
      return (nib >= 4'd5) ? (nib + 4'd3) : nib;
   endfunction

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_digit_to_seg
// Combinational BCD digit to 7-segment decoder (active-low, g..a).
// Codes 10..15 are not decimal digits and blank the display.
//   digit_i : 4-bit BCD digit
//   seg_o   : segment pattern
// -----------------------------------------------------------------------------
module bcd_digit_to_seg
   import display_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_OFF;
      case (digit_i)
         4'd0: seg_o = 7'h40;
         4'd1: seg_o = 7'h79;
         4'd2: seg_o = 7'h24;
         4'd3: seg_o = 7'h30;
         4'd4: seg_o = 7'h19;
         4'd5: seg_o = 7'h12;
         4'd6: seg_o = 7'h02;
         4'd7: seg_o = 7'h78;
         4'd8: seg_o = 7'h00;
         4'd9: seg_o = 7'h10;
         default: seg_o = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seq_value_display.sv
// -----------------------------------------------------------------------------
// seq_value_display
// Signed/unsigned binary to multi-digit 7-segment driver. Each accepted value
// is converted by a one-bit-per-cycle double-dabble engine (VALUE_W cycles),
// then the formatted segments are registered in one UPDATE cycle.
//
// Parameters:
//   VALUE_W    : input width (>= 4)
//   NUM_DIGITS : decimal digit displays (1..8); the sign display is extra
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   in_value   : value to display, sampled on the accept edge
//   in_signed  : 1 = two's complement, 0 = unsigned
//   in_valid   : request; accepted when in_valid & in_ready
//   in_ready   : idle, a request can be accepted
//   print_en   : 0 forces every display off (gates the registered segments)
//   done       : one-cycle pulse in the cycle the displays show a new value
//   overflow   : last magnitude exceeded 10^NUM_DIGITS-1
//   hex_out    : [i*7 +: 7] = digit i (0 = LSD), [NUM_DIGITS*7 +: 7] = sign
//
// Build option SEQ_DISPLAY_SIGN_FLOAT_EN: when defined, the minus sign moves
// into the blank digit just left of the most significant shown digit; the
// dedicated sign display is only used when every digit is occupied or on
// overflow. When undefined, the minus always uses the sign display.
// -----------------------------------------------------------------------------
module seq_value_display
   import display_pkg::*;
#(
   parameter int VALUE_W    = 16,
   parameter int NUM_DIGITS = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [VALUE_W-1:0]          in_value,
   input  logic                        in_signed,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        print_en,
   output logic                        done,
   output logic                        overflow,
   output logic [(NUM_DIGITS+1)*7-1:0] hex_out
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int HEX_W = (NUM_DIGITS + 1) * 7;
   localparam int CNT_W = $clog2(VALUE_W);
   // Comparison width wide enough for both the magnitude and the 64-bit limit.
   localparam int CMP_W = (VALUE_W > 64) ? VALUE_W : 64;
   localparam logic [CMP_W-1:0] MAX_SHOWN = CMP_W'(pow10(NUM_DIGITS) - 64'd1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(VALUE_W - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [VALUE_W-1:0] mag_q, mag_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               neg_q, neg_d;
   logic               ovf_pend_q, ovf_pend_d;
   logic [HEX_W-1:0]   hex_q, hex_d;
   logic               overflow_q, overflow_d;
   logic               done_q, done_d;

   // Request decode: sign and magnitude of the incoming value.
   logic               in_neg;
   logic [VALUE_W-1:0] in_mag;
   logic               in_ovf;

   assign in_neg = in_signed & in_value[VALUE_W-1];
   // The most negative value negates to itself, which read unsigned is the
   // correct magnitude 2^(VALUE_W-1).
   assign in_mag = in_neg ? (~in_value + VALUE_W'(1)) : in_value;
   assign in_ovf = CMP_W'(in_mag) > MAX_SHOWN;

   // Per-digit add-3 correction, segment decode and non-zero flags.
   logic [BCD_W-1:0]      bcd_adj;
   logic [6:0]            dig_seg [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] digit_nz;
   logic [NUM_DIGITS-1:0] above_nz;   // any digit at index >= i is non-zero

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign bcd_adj[gi*4 +: 4] = bcd_add3(bcd_q[gi*4 +: 4]);
      assign digit_nz[gi]       = |bcd_q[gi*4 +: 4];
      assign above_nz[gi]       = |digit_nz[NUM_DIGITS-1:gi];

      bcd_digit_to_seg u_seg (
         .digit_i (bcd_q[gi*4 +: 4]),
         .seg_o   (dig_seg[gi])
      );
   end

   // Display formatting from the finished BCD value; only sampled in UPDATE.
   logic [HEX_W-1:0] hex_fmt;

   always_comb begin
      hex_fmt = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (ovf_pend_q) begin
            hex_fmt[i*7 +: 7] = SEG_DASH;
         end else if (i == 0 || above_nz[i]) begin
            // Digit 0 is never blanked so zero shows as "0".
            hex_fmt[i*7 +: 7] = dig_seg[i];
         end else begin
            hex_fmt[i*7 +: 7] = SEG_OFF;
         end
      end
`ifdef SEQ_DISPLAY_SIGN_FLOAT_EN
      hex_fmt[NUM_DIGITS*7 +: 7] =
         (neg_q && (ovf_pend_q || above_nz[NUM_DIGITS-1])) ? SEG_MINUS : SEG_OFF;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         // Digit i is blank and digit i-1 is the most significant shown one.
         if (neg_q && !ovf_pend_q && !above_nz[i] && above_nz[i-1]) begin
            hex_fmt[i*7 +: 7] = SEG_MINUS;
         end
      end
`else
      hex_fmt[NUM_DIGITS*7 +: 7] = neg_q ? SEG_MINUS : SEG_OFF;
`endif
   end

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mag_d      = mag_q;
      bcd_d      = bcd_q;
      neg_d      = neg_q;
      ovf_pend_d = ovf_pend_q;
      hex_d      = hex_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d    = SHIFT;
               cnt_d      = CNT_LAST;
               mag_d      = in_mag;
               bcd_d      = '0;
               neg_d      = in_neg;
               ovf_pend_d = in_ovf;
            end
         end
         SHIFT: begin
            // {bcd, mag} <<= 1 after correction; BCD bits beyond NUM_DIGITS
            // fall off the top, which only matters on overflow.
            bcd_d = {bcd_adj[BCD_W-2:0], mag_q[VALUE_W-1]};
            mag_d = {mag_q[VALUE_W-2:0], 1'b0};
            if (cnt_q == '0) begin
               state_d = UPDATE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         UPDATE: begin
            hex_d      = hex_fmt;
            overflow_d = ovf_pend_q;
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mag_q      <= '0;
         bcd_q      <= '0;
         neg_q      <= 1'b0;
         ovf_pend_q <= 1'b0;
         hex_q      <= '1;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mag_q      <= mag_d;
         bcd_q      <= bcd_d;
         neg_q      <= neg_d;
         ovf_pend_q <= ovf_pend_d;
         hex_q      <= hex_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   assign in_ready = (state_q == IDLE);
   assign done     = done_q;
   assign overflow = overflow_q;
   assign hex_out  = print_en ? hex_q : {HEX_W{1'b1}};

endmodule

// File: tb/tb_seq_value_display.sv
// -----------------------------------------------------------------------------
// tb_seq_value_display
// Self-checking bench: two instances (NUM_DIGITS 5 and 4, VALUE_W 16) share
// data inputs; each has its own in_valid. Expected displays are pushed to a
// per-instance queue when a request is driven and compared when done pulses.
// Honors SEQ_DISPLAY_SIGN_FLOAT_EN in its reference model.
// -----------------------------------------------------------------------------
module tb_seq_value_display;

   typedef struct packed {
      logic [62:0] hex;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] in_value;
   logic        in_signed;
   logic        in_valid5, in_valid4;
   logic        print_en;
   logic        in_ready5, in_ready4;
   logic        done5, done4;
   logic        ovf5, ovf4;
   logic [41:0] hex5;
   logic [34:0] hex4;

   int checks = 0;
   int errors = 0;
   exp_t q5[$];
   exp_t q4[$];

   seq_value_display #(.VALUE_W(16), .NUM_DIGITS(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .in_value(in_value), .in_signed(in_signed),
      .in_valid(in_valid5), .in_ready(in_ready5), .print_en(print_en),
      .done(done5), .overflow(ovf5), .hex_out(hex5)
   );

   seq_value_display #(.VALUE_W(16), .NUM_DIGITS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_value(in_value), .in_signed(in_signed),
      .in_valid(in_valid4), .in_ready(in_ready4), .print_en(print_en),
      .done(done4), .overflow(ovf4), .hex_out(hex4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         default: return 7'h10;
      endcase
   endfunction

   // Reference: decimal digits by division, then blanking/sign rules.
   function automatic exp_t model(input logic [15:0] v, input logic s, input int nd);
      exp_t m;
      int mag, lim, p, msd;
      bit neg;
      int d[8];
      neg = s && v[15];
      mag = neg ? (65536 - int'(v)) : int'(v);
      lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      m.ovf = (mag > lim - 1);
      p = 1;
      msd = 0;
      for (int i = 0; i < nd; i++) begin
         d[i] = (mag / p) % 10;
         if (d[i] != 0) msd = i;
         p = p * 10;
      end
      m.hex = '1;
      for (int i = 0; i < nd; i++) begin
         if (m.ovf) m.hex[i*7 +: 7] = 7'h3F;
         else if (i > msd) m.hex[i*7 +: 7] = 7'h7F;
         else m.hex[i*7 +: 7] = seg_of(d[i]);
      end
      m.hex[nd*7 +: 7] = neg ? 7'h3F : 7'h7F;
`ifdef SEQ_DISPLAY_SIGN_FLOAT_EN
      if (neg && !m.ovf && msd < nd - 1) begin
         m.hex[(msd+1)*7 +: 7] = 7'h3F;
         m.hex[nd*7 +: 7]      = 7'h7F;
      end
`endif
      return m;
   endfunction

   // Scoreboard: pop and compare whenever a done pulse appears.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done5) begin
            checks++;
            if (q5.size() == 0) begin
               errors++;
               $display("FAIL sb5 unexpected done, hex got %h", hex5);
            end else begin
               exp_t e;
               e = q5.pop_front();
               $display("txn dut5 hex=%h ovf=%b", hex5, ovf5);
               if (hex5 !== e.hex[41:0] || ovf5 !== e.ovf) begin
                  errors++;
                  $display("FAIL sb5 hex got %h want %h ovf got %b want %b",
                           hex5, e.hex[41:0], ovf5, e.ovf);
               end
            end
         end
         if (done4) begin
            checks++;
            if (q4.size() == 0) begin
               errors++;
               $display("FAIL sb4 unexpected done, hex got %h", hex4);
            end else begin
               exp_t e;
               e = q4.pop_front();
               $display("txn dut4 hex=%h ovf=%b", hex4, ovf4);
               if (hex4 !== e.hex[34:0] || ovf4 !== e.ovf) begin
                  errors++;
                  $display("FAIL sb4 hex got %h want %h ovf got %b want %b",
                           hex4, e.hex[34:0], ovf4, e.ovf);
               end
            end
         end
      end
   end

   // Drive a request on one instance and return #1 after its accept edge.
   task automatic send(input bit which, input logic [15:0] v, input logic s,
                       input bit push, input bit hold);
      int k;
      @(negedge clk);
      in_value  = v;
      in_signed = s;
      if (which) in_valid4 = 1'b1; else in_valid5 = 1'b1;
      if (push) begin
         if (which) q4.push_back(model(v, s, 4));
         else       q5.push_back(model(v, s, 5));
      end
      k = 0;
      while (!(which ? in_ready4 : in_ready5) && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout value %h got no ready want ready", v);
      end
      @(posedge clk);
      #1;
      if (!hold) begin
         in_valid4 = 1'b0;
         in_valid5 = 1'b0;
      end
   endtask

   task automatic wait_done(input bit which);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(which ? done4 : done5) && k < 100);
      if (k >= 100) begin
         checks++;
         errors++;
         $display("FAIL done_timeout got no done want done");
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_value = '0; in_signed = 1'b0;
      in_valid5 = 1'b0; in_valid4 = 1'b0;
      print_en = 1'b1;
      repeat (3) @(negedge clk);
      checks += 4;
      if (in_ready5 !== 1'b1 || in_ready4 !== 1'b1) begin
         errors++; $display("FAIL rst_ready got %b%b want 11", in_ready5, in_ready4);
      end
      if (done5 !== 1'b0 || done4 !== 1'b0) begin
         errors++; $display("FAIL rst_done got %b%b want 00", done5, done4);
      end
      if (ovf5 !== 1'b0 || ovf4 !== 1'b0) begin
         errors++; $display("FAIL rst_ovf got %b%b want 00", ovf5, ovf4);
      end
      if (hex5 !== {42{1'b1}} || hex4 !== {35{1'b1}}) begin
         errors++; $display("FAIL rst_hex got %h %h want all ones", hex5, hex4);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned;
      int cnt;
      send(0, 16'd1234, 1'b0, 1, 0);
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready5) break;
         cnt++;
         if (cnt == 8) begin
            checks++;
            if (hex5 !== {42{1'b1}}) begin
               errors++; $display("FAIL hold_prev got %h want all ones", hex5);
            end
         end
      end
      checks += 3;
      if (cnt != 17) begin
         errors++; $display("FAIL busy_len got %0d want 17", cnt);
      end
      if (done5 !== 1'b1) begin
         errors++; $display("FAIL done_with_ready got %b want 1", done5);
      end
      @(negedge clk);
      if (done5 !== 1'b0) begin
         errors++; $display("FAIL done_pulse_len got %b want 0", done5);
      end
   endtask

   task automatic test_signed;
      logic [15:0] vals [8] = '{16'hFFF6, 16'h0000, 16'h8000, 16'hFFFF,
                                16'h8000, 16'h7FFF, 16'hFFF9, 16'd10};
      logic        sgn  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         send(0, vals[i], sgn[i], 1, 0);
         wait_done(0);
      end
      for (int i = 0; i < 6; i++) begin
         send(0, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1, 0);
         wait_done(0);
      end
   endtask

   task automatic test_overflow;
      logic [15:0] vals [6] = '{16'd12345, 16'd9999, 16'hB1E0, 16'd10000,
                                16'h0000, 16'hFC19};
      logic        sgn  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         send(1, vals[i], sgn[i], 1, 0);
         wait_done(1);
      end
   endtask

   task automatic test_back_to_back;
      exp_t e100;
      int   k;
      bit   bad;
      e100 = model(16'd100, 1'b0, 5);
      send(0, 16'd100, 1'b0, 1, 1);
      in_value = 16'd200;
      q5.push_back(model(16'd200, 1'b0, 5));
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done5 && k < 100);
      checks += 2;
      if (k != 18) begin
         errors++; $display("FAIL b2b_first_done got %0d want 18", k);
      end
      if (in_ready5 !== 1'b1) begin
         errors++; $display("FAIL b2b_ready got %b want 1", in_ready5);
      end
      @(posedge clk);
      #1;
      in_valid5 = 1'b0;
      k = 0;
      bad = 0;
      do begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            checks++;
            if (in_ready5 !== 1'b0) begin
               errors++; $display("FAIL b2b_second_busy got %b want 0", in_ready5);
            end
         end
         if (!done5 && hex5 !== e100.hex[41:0]) bad = 1;
      end while (!done5 && k < 100);
      checks += 2;
      if (k != 18) begin
         errors++; $display("FAIL b2b_second_done got %0d want 18", k);
      end
      if (bad) begin
         errors++; $display("FAIL b2b_hold got changed display want %h", e100.hex[41:0]);
      end
   endtask

   task automatic test_reset_abort;
      exp_t e;
      send(0, 16'd100, 1'b0, 0, 0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (hex5 !== {42{1'b1}}) begin
         errors++; $display("FAIL abort_hex got %h want all ones", hex5);
      end
      if (done5 !== 1'b0) begin
         errors++; $display("FAIL abort_done got %b want 0", done5);
      end
      if (in_ready5 !== 1'b1) begin
         errors++; $display("FAIL abort_ready got %b want 1", in_ready5);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send(0, 16'd4321, 1'b0, 1, 0);
      wait_done(0);
      // Display gating with print_en
      e = model(16'd4321, 1'b0, 5);
      @(negedge clk);
      print_en = 1'b0;
      #1;
      checks += 2;
      if (hex5 !== {42{1'b1}}) begin
         errors++; $display("FAIL print_off got %h want all ones", hex5);
      end
      print_en = 1'b1;
      #1;
      if (hex5 !== e.hex[41:0]) begin
         errors++; $display("FAIL print_on got %h want %h", hex5, e.hex[41:0]);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_overflow();
      test_back_to_back();
      test_reset_abort();
      repeat (3) @(negedge clk);
      checks++;
      if (q5.size() != 0 || q4.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d/%0d want 0/0", q5.size(), q4.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
